voice_allocator: RTL and testbench

//  Accepts note-on/note-off requests and assigns them to the N oscillator voices (wave_gens[]).

---
 rtl/protocol_pkg.sv | 29 ++
 rtl/voice_age_tracker.sv | 45 ++++
 rtl/voice_allocator.sv | 145 ++++++++++++++
 tb/tb_voice_allocator.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/protocol_pkg.sv
// rtl/protocol_pkg.sv - shared types and constants for the voice allocator
// Purpose: request record, wave generator command encodings and default widths
//          shared by the allocator, its age tracker and the surrounding synth chain.
// Ports:   none (package).
package protocol_pkg;

    localparam int N_OSCILLATORS  = 4;
    localparam int FIXED_POINT    = 16;
    localparam int PKG_FREQ_WIDTH = 32;
    localparam int PKG_ID_WIDTH   = 7;

    localparam logic [7:0] WAVEGEN_CMD_OFF   = 8'b00;
    localparam logic [7:0] WAVEGEN_CMD_RESET = 8'b11;
    localparam logic [7:0] WAVEGEN_CMD_RUN   = 8'b10;

    typedef struct packed {
        logic                      on;
        logic [PKG_ID_WIDTH-1:0]   id;
        logic [PKG_FREQ_WIDTH-1:0] freq;
    } voice_req_t;

    // Frequency given in hundredths of a hertz -> fixed-point word.
    function automatic logic [PKG_FREQ_WIDTH-1:0] centihz_to_fixed(input int unsigned centihz);
        logic [63:0] wide;
        wide = (64'(centihz) << FIXED_POINT) / 64'd100;
        return wide[PKG_FREQ_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/voice_age_tracker.sv
// rtl/voice_age_tracker.sv - least-recently-allocated ranking of voices
// Purpose: keeps one age rank per voice (0 = most recently touched), always a
//          permutation of 0..N-1, and reports the voice with the highest rank.
// Ports:   clk, rstn (async active-low), touch_valid/touch_idx (voice just
//          allocated), ranks (current rank per voice), oldest_idx (steal victim).
module voice_age_tracker #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      touch_valid,
    input  logic [IDX_W-1:0]          touch_idx,
    output logic [N-1:0][IDX_W-1:0]   ranks,
    output logic [IDX_W-1:0]          oldest_idx
);

    logic [N-1:0][IDX_W-1:0] ranks_q;

    // Touched voice becomes rank 0; only voices younger than it age by one,
    // so the set stays a permutation and no rank ever wraps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N; i++) ranks_q[i] <= IDX_W'(i);
        end else if (touch_valid) begin
            for (int i = 0; i < N; i++) begin
                if (IDX_W'(i) == touch_idx) begin
                    ranks_q[i] <= '0;
                end else if (ranks_q[i] < ranks_q[touch_idx]) begin
                    ranks_q[i] <= ranks_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        oldest_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (ranks_q[i] == IDX_W'(N - 1)) oldest_idx = IDX_W'(i);
        end
    end

    assign ranks = ranks_q;

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - note-on/note-off to oscillator voice allocation
// Purpose: assigns note requests to N voices, sequences the envelope restart
//          (RESET for RESET_HOLD cycles, then RUN), steals the oldest voice when
//          all are busy, and reports the enabled-voice count to the mixer.
// Ports:   clk, rstn (async active-low); req_valid/req_ready handshake with
//          req_on, req_id, req_freq; per-voice voice_cmds/voice_freq;
//          num_enabled (lags cmds by one cycle); stolen (one-cycle pulse).
module voice_allocator
    import protocol_pkg::*;
#(
    parameter int N_VOICES   = N_OSCILLATORS,
    parameter int FREQ_WIDTH = PKG_FREQ_WIDTH,
    parameter int ID_WIDTH   = PKG_ID_WIDTH,
    parameter int RESET_HOLD = 2
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic                                 req_on,
    input  logic [ID_WIDTH-1:0]                  req_id,
    input  logic [FREQ_WIDTH-1:0]                req_freq,
    output logic [N_VOICES-1:0][7:0]             voice_cmds,
    output logic [N_VOICES-1:0][FREQ_WIDTH-1:0]  voice_freq,
    output logic signed [31:0]                   num_enabled,
    output logic                                 stolen
);

    localparam int IDX_W = $clog2(N_VOICES);
    localparam int CNT_W = $clog2(RESET_HOLD + 1);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t                              state_q;
    logic                                ready_q;
    logic [CNT_W-1:0]                    hold_cnt_q;
    logic [IDX_W-1:0]                    hold_idx_q;
    logic                                stolen_q;
    logic signed [31:0]                  num_q;
    logic [N_VOICES-1:0][7:0]            cmds_q;
    logic [N_VOICES-1:0][FREQ_WIDTH-1:0] freq_q;
    logic [N_VOICES-1:0]                 busy_q;
    logic [N_VOICES-1:0][ID_WIDTH-1:0]   id_q;

    voice_req_t       req;
    logic             transfer;
    logic             match_hit, free_hit;
    logic [IDX_W-1:0] match_idx, free_idx, oldest_idx, sel_idx;
    logic [31:0]      en_cnt;
    logic [N_VOICES-1:0][IDX_W-1:0] ranks;

    assign req      = '{on: req_on, id: req_id, freq: req_freq};
    assign transfer = req_valid && ready_q;

    // First-match priority encoders: lowest index wins in both searches.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        for (int i = 0; i < N_VOICES; i++) begin
            if (!match_hit && busy_q[i] && id_q[i] == req.id) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (!free_hit && !busy_q[i]) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign sel_idx = match_hit ? match_idx : (free_hit ? free_idx : oldest_idx);

    always_comb begin
        en_cnt = '0;
        for (int i = 0; i < N_VOICES; i++) en_cnt = en_cnt + {31'b0, cmds_q[i][1]};
    end

    voice_age_tracker #(.N(N_VOICES), .IDX_W(IDX_W)) u_age (
        .clk        (clk),
        .rstn       (rstn),
        .touch_valid(transfer && req.on),
        .touch_idx  (sel_idx),
        .ranks      (ranks),
        .oldest_idx (oldest_idx)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            hold_cnt_q <= '0;
            hold_idx_q <= '0;
            stolen_q   <= 1'b0;
            num_q      <= '0;
            cmds_q     <= '0;
            freq_q     <= '0;
            busy_q     <= '0;
            id_q       <= '0;
        end else begin
            num_q    <= $signed(en_cnt);
            stolen_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (transfer) begin
                        if (req.on) begin
                            cmds_q[sel_idx] <= WAVEGEN_CMD_RESET;
                            freq_q[sel_idx] <= req.freq;
                            busy_q[sel_idx] <= 1'b1;
                            id_q[sel_idx]   <= req.id;
                            stolen_q        <= !match_hit && !free_hit;
                            hold_idx_q      <= sel_idx;
                            hold_cnt_q      <= CNT_W'(RESET_HOLD - 1);
                            ready_q         <= 1'b0;
                            state_q         <= S_HOLD;
                        end else if (match_hit) begin
                            // Frequency and rank are deliberately left alone.
                            cmds_q[match_idx] <= WAVEGEN_CMD_OFF;
                            busy_q[match_idx] <= 1'b0;
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_cnt_q == '0) begin
                        cmds_q[hold_idx_q] <= WAVEGEN_CMD_RUN;
                        ready_q            <= 1'b1;
                        state_q            <= S_IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = ready_q;
    assign voice_cmds  = cmds_q;
    assign voice_freq  = freq_q;
    assign num_enabled = num_q;
    assign stolen      = stolen_q;

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - self-checking bench for voice_allocator
module tb_voice_allocator;
    import protocol_pkg::*;

    localparam int N  = 4;
    localparam int H  = 2;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   req_valid, req_on;
    logic [6:0]             req_id;
    logic [31:0]            req_freq;
    logic                   req_ready;
    logic [N-1:0][7:0]      voice_cmds;
    logic [N-1:0][31:0]     voice_freq;
    logic signed [31:0]     num_enabled;
    logic                   stolen;

    voice_allocator #(.N_VOICES(N), .FREQ_WIDTH(32), .ID_WIDTH(7), .RESET_HOLD(H)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_on(req_on), .req_id(req_id), .req_freq(req_freq),
        .voice_cmds(voice_cmds), .voice_freq(voice_freq),
        .num_enabled(num_enabled), .stolen(stolen)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: plain per-voice arrays and a recency list (front = newest).
    logic [7:0]  m_cmds[N];
    logic [31:0] m_freq[N];
    bit          m_busy[N];
    logic [6:0]  m_id[N];
    int          lru[$];
    bit          m_ready, m_stolen;
    int          m_num, m_hold_left, m_hold_idx;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int lru_pos(input int v);
        for (int k = 0; k < lru.size(); k++) if (lru[k] == v) return k;
        return -1;
    endfunction

    function automatic logic [31:0] fx(input int unsigned centihz);
        longint unsigned w;
        w = (longint'(centihz) << FIXED_POINT) / 100;
        return w[31:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cmds[i] = 8'h00; m_freq[i] = '0; m_busy[i] = 0; m_id[i] = '0;
        end
        lru.delete();
        for (int i = 0; i < N; i++) lru.push_back(i);
        m_ready = 0; m_stolen = 0; m_num = 0; m_hold_left = 0; m_hold_idx = 0;
    endtask

    task automatic model_step(input bit v, input bit on, input logic [6:0] id, input logic [31:0] f);
        int prev_en, sel, p;
        prev_en = 0;
        for (int i = 0; i < N; i++) prev_en += int'(m_cmds[i][1]);
        m_stolen = 0;
        if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) begin
                m_cmds[m_hold_idx] = 8'b10;
                m_ready = 1;
            end
        end else if (v && m_ready) begin
            sel = -1;
            for (int i = 0; i < N; i++) if (sel < 0 && m_busy[i] && m_id[i] == id) sel = i;
            if (on) begin
                if (sel < 0) for (int i = 0; i < N; i++) if (sel < 0 && !m_busy[i]) sel = i;
                if (sel < 0) begin
                    sel = lru[lru.size() - 1];
                    m_stolen = 1;
                end
                m_cmds[sel] = 8'b11; m_freq[sel] = f; m_busy[sel] = 1; m_id[sel] = id;
                p = lru_pos(sel);
                lru.delete(p);
                lru.push_front(sel);
                m_ready = 0; m_hold_left = H; m_hold_idx = sel;
            end else if (sel >= 0) begin
                m_cmds[sel] = 8'b00; m_busy[sel] = 0;
            end
        end else begin
            m_ready = 1;
        end
        m_num = prev_en;
    endtask

    task automatic compare_all();
        chk("ready", req_ready, m_ready);
        chk("stolen", stolen, m_stolen);
        chk("num_enabled", num_enabled, m_num);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("cmds%0d", i), voice_cmds[i], m_cmds[i]);
            chk($sformatf("freq%0d", i), voice_freq[i], m_freq[i]);
            chk($sformatf("rank%0d", i), dut.u_age.ranks[i], lru_pos(i));
        end
    endtask

    task automatic cycle(input bit v, input bit on, input logic [6:0] id, input logic [31:0] f);
        req_valid = v; req_on = on; req_id = id; req_freq = f;
        @(posedge clk);
        model_step(v, on, id, f);
        #1;
        compare_all();
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!req_ready && k < 20) begin
            cycle(0, 0, 7'd0, 32'd0);
            k++;
        end
        chk("ready_before_req", req_ready, 1);
    endtask

    task automatic apply_reset();
        req_valid = 0; req_on = 0; req_id = '0; req_freq = '0;
        rstn = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        compare_all();
        @(negedge clk);
        rstn = 1;
    endtask

    typedef struct {
        bit          on;
        logic [6:0]  id;
        int unsigned centihz;
        int          exp_idx;
        logic [7:0]  exp_cmds;
        bit          exp_stolen;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1, 7'd69,  44000, 0, 8'h03, 0};
        tbl[1]  = '{1, 7'd64,  32963, 1, 8'h03, 0};
        tbl[2]  = '{1, 7'd61,  27718, 2, 8'h03, 0};
        tbl[3]  = '{0, 7'd64,  0,     1, 8'h00, 0};
        tbl[4]  = '{1, 7'd62,  29366, 1, 8'h03, 0};
        tbl[5]  = '{1, 7'd70,  46616, 3, 8'h03, 0};
        tbl[6]  = '{1, 7'd99,  12000, 0, 8'h03, 1};
        tbl[7]  = '{1, 7'd100, 13000, 2, 8'h03, 1};
        tbl[8]  = '{1, 7'd99,  12500, 0, 8'h03, 0};
        tbl[9]  = '{0, 7'd42,  0,    -1, 8'h00, 0};
        tbl[10] = '{0, 7'd100, 0,     2, 8'h00, 0};
        tbl[11] = '{1, 7'd60,  26163, 2, 8'h03, 0};
        tbl[12] = '{1, 7'd60,  26163, 2, 8'h03, 0};

        // Reset state and first note-on envelope sequence.
        apply_reset();
        cycle(0, 0, 7'd0, 32'd0);
        chk("ready_after_release", req_ready, 1);
        cycle(1, 1, 7'd69, fx(44000));
        chk("t1_cmds_reset0", voice_cmds[0], 8'h03);
        chk("t1_freq", voice_freq[0], 32'd440 << FIXED_POINT);
        chk("t1_num_lag", num_enabled, 0);
        cycle(0, 0, 7'd0, 32'd0);
        chk("t1_cmds_reset1", voice_cmds[0], 8'h03);
        chk("t1_num", num_enabled, 1);
        cycle(0, 0, 7'd0, 32'd0);
        chk("t1_cmds_run", voice_cmds[0], 8'h02);
        chk("t1_ready_back", req_ready, 1);

        // Directed allocation / release / steal / retrigger table.
        apply_reset();
        foreach (tbl[k]) begin
            wait_ready();
            cycle(1, tbl[k].on, tbl[k].id, fx(tbl[k].centihz));
            if (tbl[k].exp_idx >= 0)
                chk($sformatf("tbl%0d_cmds", k), voice_cmds[tbl[k].exp_idx], tbl[k].exp_cmds);
            chk($sformatf("tbl%0d_stolen", k), stolen, tbl[k].exp_stolen);
        end
        wait_ready();
        chk("tbl_num_after_retrigger", num_enabled, 4);

        // Back-to-back note-offs, matching and not.
        cycle(1, 0, 7'd42, 32'd0);
        chk("off_miss_ready", req_ready, 1);
        cycle(1, 0, 7'd99, 32'd0);
        chk("off_b2b_v0", voice_cmds[0], 8'h00);
        cycle(1, 0, 7'd62, 32'd0);
        chk("off_b2b_v1", voice_cmds[1], 8'h00);
        chk("off_b2b_ready", req_ready, 1);

        // Reset asserted during HOLD.
        wait_ready();
        cycle(1, 1, 7'd5, fx(50000));
        #2 rstn = 0;
        #1;
        model_reset();
        compare_all();
        chk("rst_mid_hold_num", num_enabled, 0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rstn = 1;
        cycle(0, 0, 7'd0, 32'd0);
        cycle(1, 1, 7'd77, fx(60000));
        chk("post_rst_voice0", voice_cmds[0], 8'h03);

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6,
                  7'($urandom_range(0, 7)), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
